// File: rtl/decode_stage_pipe_if.sv
// Fetch-side and execute-side signals of the RV32 decode stage, in one bundle.
// The slave modport is the decode stage; the master modport drives it.
interface decode_stage_pipe_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          instr_in;
    logic [PC_WIDTH-1:0]  pc_in;
    logic                 in_valid_in;
    logic                 in_ready_out;
    logic                 flush_in;
    logic                 out_ready_in;
    logic                 out_valid_out;
    logic [PC_WIDTH-1:0]  pc_out;
    logic [4:0]           rd_addr_out;
    logic [4:0]           rs1_addr_out;
    logic [4:0]           rs2_addr_out;
    logic [31:0]          imm_out;
    logic [2:0]           imm_type_out;
    logic [4:0]           alu_opcode_out;
    logic                 alu_src_out;
    logic                 iadder_src_out;
    logic [2:0]           wb_mux_sel_out;
    logic                 wr_en_out;
    logic                 mem_wr_req_out;
    logic                 mem_rd_req_out;
    logic [1:0]           load_size_out;
    logic                 load_unsigned_out;
    logic                 branch_out;
    logic                 jump_out;
    logic                 csr_op_out;
    logic                 ecall_out;
    logic                 ebreak_out;
    logic                 fence_out;
    logic                 illegal_out;
    logic [CNT_WIDTH-1:0] dec_count_out;

    modport slave (
        input  instr_in, pc_in, in_valid_in, flush_in, out_ready_in,
        output in_ready_out, out_valid_out, pc_out, rd_addr_out, rs1_addr_out,
               rs2_addr_out, imm_out, imm_type_out, alu_opcode_out, alu_src_out,
               iadder_src_out, wb_mux_sel_out, wr_en_out, mem_wr_req_out,
               mem_rd_req_out, load_size_out, load_unsigned_out, branch_out,
               jump_out, csr_op_out, ecall_out, ebreak_out, fence_out,
               illegal_out, dec_count_out
    );

    modport master (
        output instr_in, pc_in, in_valid_in, flush_in, out_ready_in,
        input  in_ready_out, out_valid_out, pc_out, rd_addr_out, rs1_addr_out,
               rs2_addr_out, imm_out, imm_type_out, alu_opcode_out, alu_src_out,
               iadder_src_out, wb_mux_sel_out, wr_en_out, mem_wr_req_out,
               mem_rd_req_out, load_size_out, load_unsigned_out, branch_out,
               jump_out, csr_op_out, ecall_out, ebreak_out, fence_out,
               illegal_out, dec_count_out
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered RV32 decode (base + optional M / Zicsr) with illegal detection.
// Latency 1 cycle from accept to decoded bundle on the outputs.
// in_ready = !out_valid | out_ready (no skid); stall holds the bundle, flush drops it.
module decode_stage_pipe #(
    parameter bit EN_M_EXT  = 1'b1,
    parameter bit EN_CSR    = 1'b1,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    decode_stage_pipe_if.slave bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic [4:0]  alu_opcode;
        logic        alu_src;
        logic        iadder_src;
        logic [2:0]  wb_mux_sel;
        logic        wr_en;
        logic        mem_wr_req;
        logic        mem_rd_req;
        logic [1:0]  load_size;
        logic        load_unsigned;
        logic        branch;
        logic        jump;
        logic        csr_op;
        logic        ecall;
        logic        ebreak;
        logic        fence;
        logic        illegal;
    } dec_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign instr  = bus.instr_in;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    dec_t dec_d, dec_q;
    logic ill, writes_rd, st, ld, br, jmp, csr;

    always_comb begin
        dec_d                = '0;
        ill                  = 1'b0;
        writes_rd            = 1'b0;
        st                   = 1'b0;
        ld                   = 1'b0;
        br                   = 1'b0;
        jmp                  = 1'b0;
        csr                  = 1'b0;
        dec_d.rd_addr        = instr[11:7];
        dec_d.rs1_addr       = instr[19:15];
        dec_d.rs2_addr       = instr[24:20];
        dec_d.alu_opcode[2:0] = funct3;
        dec_d.load_size      = funct3[1:0];
        dec_d.load_unsigned  = funct3[2];
        case (opcode)
            OPC_LOAD: begin
                dec_d.imm_type   = 3'd1;
                dec_d.imm        = imm_i;
                dec_d.iadder_src = 1'b1;
                dec_d.wb_mux_sel = 3'd1;
                writes_rd        = 1'b1;
                ld               = 1'b1;
                ill              = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_d.imm_type   = 3'd2;
                dec_d.imm        = imm_s;
                dec_d.iadder_src = 1'b1;
                st               = 1'b1;
                ill              = (funct3 > 3'b010);
            end
            OPC_OP: begin
                dec_d.alu_src       = 1'b1;
                dec_d.alu_opcode[3] = instr[30];
                writes_rd           = 1'b1;
                if (EN_M_EXT && (funct7 == 7'b0000001)) begin
                    dec_d.alu_opcode[4] = 1'b1;
                end else if (funct7 == 7'b0100000) begin
                    ill = !((funct3 == 3'b000) || (funct3 == 3'b101));
                end else begin
                    ill = (funct7 != 7'b0000000);
                end
            end
            OPC_OP_IMM: begin
                dec_d.imm_type = 3'd1;
                dec_d.imm      = imm_i;
                writes_rd      = 1'b1;
                // Shift-immediates reuse funct7 as the arithmetic/logical select.
                if (funct3 == 3'b001) begin
                    dec_d.alu_opcode[3] = instr[30];
                    ill                 = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec_d.alu_opcode[3] = instr[30];
                    ill = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
                end
            end
            OPC_BRANCH: begin
                dec_d.imm_type = 3'd3;
                dec_d.imm      = imm_b;
                dec_d.alu_src  = 1'b1;
                br             = 1'b1;
                ill            = (funct3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                dec_d.imm_type   = 3'd5;
                dec_d.imm        = imm_j;
                dec_d.wb_mux_sel = 3'd5;
                writes_rd        = 1'b1;
                jmp              = 1'b1;
            end
            OPC_JALR: begin
                dec_d.imm_type   = 3'd1;
                dec_d.imm        = imm_i;
                dec_d.iadder_src = 1'b1;
                dec_d.wb_mux_sel = 3'd5;
                writes_rd        = 1'b1;
                jmp              = 1'b1;
            end
            OPC_LUI: begin
                dec_d.imm_type   = 3'd4;
                dec_d.imm        = imm_u;
                dec_d.wb_mux_sel = 3'd2;
                writes_rd        = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.imm_type   = 3'd4;
                dec_d.imm        = imm_u;
                dec_d.wb_mux_sel = 3'd3;
                writes_rd        = 1'b1;
            end
            OPC_MISC: dec_d.fence = 1'b1;
            OPC_SYSTEM: begin
                if (funct3 != 3'b000) begin
                    // CSR address rides in imm; the zimm source is already rs1_addr.
                    dec_d.imm_type   = 3'd6;
                    dec_d.imm        = {20'b0, instr[31:20]};
                    dec_d.wb_mux_sel = 3'd4;
                    writes_rd        = 1'b1;
                    csr              = 1'b1;
                    ill              = !EN_CSR;
                end else begin
                    dec_d.ecall  = (instr[31:20] == 12'h000);
                    dec_d.ebreak = (instr[31:20] == 12'h001);
                    ill          = !(dec_d.ecall || dec_d.ebreak);
                end
            end
            default: ill = 1'b1;
        endcase
        dec_d.illegal    = ill;
        dec_d.wr_en      = writes_rd && (instr[11:7] != 5'd0) && !ill;
        dec_d.mem_wr_req = st && !ill;
        dec_d.mem_rd_req = ld && !ill;
        dec_d.branch     = br && !ill;
        dec_d.jump       = jmp && !ill;
        dec_d.csr_op     = csr && !ill;
    end

    logic                 out_vld_q;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 in_rdy, accept;

    assign in_rdy = !out_vld_q || bus.out_ready_in;
    assign accept = bus.in_valid_in && in_rdy && !bus.flush_in;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            out_vld_q <= 1'b0;
            dec_q     <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
        end else if (accept) begin
            out_vld_q <= 1'b1;
            dec_q     <= dec_d;
            pc_q      <= bus.pc_in;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end else if (bus.flush_in || bus.out_ready_in) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.in_ready_out      = in_rdy;
    assign bus.out_valid_out     = out_vld_q;
    assign bus.pc_out            = pc_q;
    assign bus.rd_addr_out       = dec_q.rd_addr;
    assign bus.rs1_addr_out      = dec_q.rs1_addr;
    assign bus.rs2_addr_out      = dec_q.rs2_addr;
    assign bus.imm_out           = dec_q.imm;
    assign bus.imm_type_out      = dec_q.imm_type;
    assign bus.alu_opcode_out    = dec_q.alu_opcode;
    assign bus.alu_src_out       = dec_q.alu_src;
    assign bus.iadder_src_out    = dec_q.iadder_src;
    assign bus.wb_mux_sel_out    = dec_q.wb_mux_sel;
    assign bus.wr_en_out         = dec_q.wr_en;
    assign bus.mem_wr_req_out    = dec_q.mem_wr_req;
    assign bus.mem_rd_req_out    = dec_q.mem_rd_req;
    assign bus.load_size_out     = dec_q.load_size;
    assign bus.load_unsigned_out = dec_q.load_unsigned;
    assign bus.branch_out        = dec_q.branch;
    assign bus.jump_out          = dec_q.jump;
    assign bus.csr_op_out        = dec_q.csr_op;
    assign bus.ecall_out         = dec_q.ecall;
    assign bus.ebreak_out        = dec_q.ebreak;
    assign bus.fence_out         = dec_q.fence;
    assign bus.illegal_out       = dec_q.illegal;
    assign bus.dec_count_out     = cnt_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: a full-featured instance (M, CSR, 16-bit count) and a
// minimal one (no M, no CSR, 4-bit count) share stimulus and are checked against a reference.
module tb_decode_stage_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, pc;
    logic        in_valid, flush, out_ready;

    always #5 clk = ~clk;

    decode_stage_pipe_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
    decode_stage_pipe_if #(.PC_WIDTH(32), .CNT_WIDTH(4))  bus_b ();

    assign bus_a.instr_in = instr;    assign bus_b.instr_in = instr;
    assign bus_a.pc_in = pc;          assign bus_b.pc_in = pc;
    assign bus_a.in_valid_in = in_valid;  assign bus_b.in_valid_in = in_valid;
    assign bus_a.flush_in = flush;    assign bus_b.flush_in = flush;
    assign bus_a.out_ready_in = out_ready; assign bus_b.out_ready_in = out_ready;

    decode_stage_pipe #(.EN_M_EXT(1'b1), .EN_CSR(1'b1), .PC_WIDTH(32), .CNT_WIDTH(16)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .bus(bus_a.slave));
    decode_stage_pipe #(.EN_M_EXT(1'b0), .EN_CSR(1'b0), .PC_WIDTH(32), .CNT_WIDTH(4)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .bus(bus_b.slave));

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic [4:0]  alu_opcode;
        logic        alu_src, iadder_src;
        logic [2:0]  wb;
        logic        wr_en, mem_wr, mem_rd;
        logic [1:0]  load_size;
        logic        load_unsigned, branch, jump, csr_op, ecall, ebreak, fence, illegal;
    } exp_t;

    exp_t obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {bus_a.pc_out, bus_a.rd_addr_out, bus_a.rs1_addr_out, bus_a.rs2_addr_out,
                    bus_a.imm_out, bus_a.imm_type_out, bus_a.alu_opcode_out, bus_a.alu_src_out,
                    bus_a.iadder_src_out, bus_a.wb_mux_sel_out, bus_a.wr_en_out, bus_a.mem_wr_req_out,
                    bus_a.mem_rd_req_out, bus_a.load_size_out, bus_a.load_unsigned_out, bus_a.branch_out,
                    bus_a.jump_out, bus_a.csr_op_out, bus_a.ecall_out, bus_a.ebreak_out,
                    bus_a.fence_out, bus_a.illegal_out};
    assign obs_b = {bus_b.pc_out, bus_b.rd_addr_out, bus_b.rs1_addr_out, bus_b.rs2_addr_out,
                    bus_b.imm_out, bus_b.imm_type_out, bus_b.alu_opcode_out, bus_b.alu_src_out,
                    bus_b.iadder_src_out, bus_b.wb_mux_sel_out, bus_b.wr_en_out, bus_b.mem_wr_req_out,
                    bus_b.mem_rd_req_out, bus_b.load_size_out, bus_b.load_unsigned_out, bus_b.branch_out,
                    bus_b.jump_out, bus_b.csr_op_out, bus_b.ecall_out, bus_b.ebreak_out,
                    bus_b.fence_out, bus_b.illegal_out};

    int n_checks = 0;
    int n_errors = 0;
    bit exp_vld = 1'b0;
    bit model_known = 1'b0;
    int cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode, written instruction-class by instruction-class from the ISA rules.
    function automatic exp_t decode_ref(input logic [31:0] ins, input bit en_m, input bit en_csr);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit ld, st, opr, opi, br, jal, jalr, lui, auipc, fen, sys, csr, shi, mext, ill, writes;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ld = op == 7'h03; st = op == 7'h23; opr = op == 7'h33; opi = op == 7'h13;
        br = op == 7'h63; jal = op == 7'h6f; jalr = op == 7'h67; lui = op == 7'h37;
        auipc = op == 7'h17; fen = op == 7'h0f; sys = op == 7'h73;
        csr  = sys && (f3 != 0);
        shi  = opi && (f3 == 3'd1 || f3 == 3'd5);
        mext = opr && (f7 == 7'h01);
        ill = !(ld || st || opr || opi || br || jal || jalr || lui || auipc || fen || sys);
        if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) ill = 1;
        if (st && f3 > 2) ill = 1;
        if (br && (f3 == 2 || f3 == 3)) ill = 1;
        if (opr && !(f7 == 7'h00 || f7 == 7'h20 || (mext && en_m))) ill = 1;
        if (opr && f7 == 7'h20 && !(f3 == 0 || f3 == 5)) ill = 1;
        if (shi && !(f7 == 7'h00 || (f3 == 5 && f7 == 7'h20))) ill = 1;
        if (csr && !en_csr) ill = 1;
        if (sys && f3 == 0 && ins[31:20] > 12'd1) ill = 1;
        e = '0;
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        if (ld || opi || jalr) begin e.imm_type = 1; e.imm = 32'($signed(ins[31:20])); end
        if (st)  begin e.imm_type = 2; e.imm = 32'($signed({ins[31:25], ins[11:7]})); end
        if (br)  begin e.imm_type = 3; e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
        if (lui || auipc) begin e.imm_type = 4; e.imm = {ins[31:12], 12'h000}; end
        if (jal) begin e.imm_type = 5; e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
        if (csr) begin e.imm_type = 6; e.imm = {20'h0, ins[31:20]}; end
        e.alu_opcode = {mext && en_m, (opr || shi) && ins[30], f3};
        e.alu_src = opr || br;
        e.iadder_src = ld || st || jalr;
        e.wb = ld ? 3'd1 : lui ? 3'd2 : auipc ? 3'd3 : csr ? 3'd4 : (jal || jalr) ? 3'd5 : 3'd0;
        writes = ld || opr || opi || jal || jalr || lui || auipc || csr;
        e.wr_en = writes && (ins[11:7] != 0) && !ill;
        e.mem_wr = st && !ill; e.mem_rd = ld && !ill; e.branch = br && !ill;
        e.jump = (jal || jalr) && !ill; e.csr_op = csr && !ill;
        e.load_size = f3[1:0]; e.load_unsigned = f3[2];
        e.ecall = sys && f3 == 0 && ins[31:20] == 0;
        e.ebreak = sys && f3 == 0 && ins[31:20] == 1;
        e.fence = fen; e.illegal = ill;
        return e;
    endfunction

    task automatic cmp_bundle(input string who, input exp_t o, input exp_t e);
        check({who, "_pc"}, o.pc, e.pc);             check({who, "_rd"}, o.rd, e.rd);
        check({who, "_rs1"}, o.rs1, e.rs1);          check({who, "_rs2"}, o.rs2, e.rs2);
        check({who, "_imm"}, o.imm, e.imm);          check({who, "_imm_type"}, o.imm_type, e.imm_type);
        check({who, "_alu_opcode"}, o.alu_opcode, e.alu_opcode);
        check({who, "_alu_src"}, o.alu_src, e.alu_src);
        check({who, "_iadder_src"}, o.iadder_src, e.iadder_src);
        check({who, "_wb_mux_sel"}, o.wb, e.wb);     check({who, "_wr_en"}, o.wr_en, e.wr_en);
        check({who, "_mem_wr"}, o.mem_wr, e.mem_wr); check({who, "_mem_rd"}, o.mem_rd, e.mem_rd);
        check({who, "_load_size"}, o.load_size, e.load_size);
        check({who, "_load_unsigned"}, o.load_unsigned, e.load_unsigned);
        check({who, "_branch"}, o.branch, e.branch); check({who, "_jump"}, o.jump, e.jump);
        check({who, "_csr_op"}, o.csr_op, e.csr_op); check({who, "_ecall"}, o.ecall, e.ecall);
        check({who, "_ebreak"}, o.ebreak, e.ebreak); check({who, "_fence"}, o.fence, e.fence);
        check({who, "_illegal"}, o.illegal, e.illegal);
    endtask

    // Drive one cycle of inputs just after a falling edge, check, then advance the model.
    task automatic step(input logic [31:0] i, input bit v, input bit fl, input bit ordy, input bit rn);
        bit acc;
        instr = i; pc = $urandom; in_valid = v; flush = fl; out_ready = ordy; rst_n = rn;
        #1;
        if (model_known) begin
            check("in_ready_a", bus_a.in_ready_out, !exp_vld || ordy);
            check("in_ready_b", bus_b.in_ready_out, !exp_vld || ordy);
        end
        acc = rn && v && (!exp_vld || ordy) && !fl;
        if (!rn) begin
            exp_vld = 0; cnt = 0; exp_a = '0; exp_b = '0;
        end else if (acc) begin
            exp_vld = 1; cnt++;
            exp_a = decode_ref(i, 1'b1, 1'b1); exp_a.pc = pc;
            exp_b = decode_ref(i, 1'b0, 1'b0); exp_b.pc = pc;
        end else if (fl || ordy) begin
            exp_vld = 0;
        end
        model_known = 1;
        @(posedge clk);
        @(negedge clk);
        check("out_valid_a", bus_a.out_valid_out, exp_vld);
        check("out_valid_b", bus_b.out_valid_out, exp_vld);
        check("count_a", bus_a.dec_count_out, (cnt > 65535) ? 65535 : cnt);
        check("count_b", bus_b.dec_count_out, (cnt > 15) ? 15 : cnt);
        if (exp_vld || !rn) begin
            cmp_bundle("a", obs_a, exp_a);
            cmp_bundle("b", obs_b, exp_b);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [0:10];
        int k;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
        r = $urandom;
        k = int'($urandom_range(0, 14));
        if (k < 11) r[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        if (r[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
            r[14:12] = 3'd0;
            r[31:20] = 12'($urandom_range(0, 2));
        end
        return r;
    endfunction

    initial begin
        int c0;
        instr = '0; pc = '0; in_valid = 0; flush = 0; out_ready = 0; rst_n = 0;
        step(32'h0, 1, 0, 1, 0);
        step(32'h0, 1, 0, 1, 0);
        check("reset_valid", bus_a.out_valid_out, 0);

        step(32'hFFF00093, 1, 0, 1, 1);                    // ADDI x1,x0,-1
        check("addi_imm", bus_a.imm_out, 32'hFFFFFFFF);
        check("addi_imm_type", bus_a.imm_type_out, 1);
        check("addi_alu", bus_a.alu_opcode_out, 5'b00000);
        check("addi_wr_en", bus_a.wr_en_out, 1);
        check("addi_count", bus_a.dec_count_out, 1);
        step(32'h40315113, 1, 0, 1, 1);                    // SRAI
        check("srai_alu", bus_a.alu_opcode_out, 5'b01101);
        step(32'h40208033, 1, 0, 1, 1);                    // SUB
        check("sub_alu", bus_a.alu_opcode_out, 5'b01000);
        step(32'h02208033, 1, 0, 1, 1);                    // MUL
        check("mul_alu_m", bus_a.alu_opcode_out, 5'b10000);
        check("mul_illegal_nom", bus_b.illegal_out, 1);
        check("mul_wr_en_nom", bus_b.wr_en_out, 0);

        step(32'h008000EF, 1, 0, 1, 1);                    // JAL x1,8 then stall
        for (int n = 0; n < 3; n++) begin
            step(32'h00500113, 1, 0, 0, 1);
            check("hold_in_ready", bus_a.in_ready_out, 0);
            check("hold_imm", bus_a.imm_out, 8);
            check("hold_jump", bus_a.jump_out, 1);
            check("hold_wb", bus_a.wb_mux_sel_out, 5);
        end
        c0 = cnt;
        step(32'h00500113, 1, 0, 1, 1);
        check("release_accept", bus_a.dec_count_out, c0 + 1);

        c0 = cnt;
        step(32'h00700193, 1, 1, 0, 1);                    // flush while valid
        check("flush_valid", bus_a.out_valid_out, 0);
        check("flush_count", bus_a.dec_count_out, c0);

        step(32'h00000000, 1, 0, 1, 1);
        check("zero_illegal", bus_b.illegal_out, 1);
        step(32'hFFFFFFFF, 1, 0, 1, 1);
        check("ones_illegal", bus_b.illegal_out, 1);
        step(32'h30529073, 1, 0, 1, 1);                    // CSRRW x0,mstatus-ish,x5
        check("csr_illegal_nocsr", bus_b.illegal_out, 1);
        check("csr_op", bus_a.csr_op_out, 1);
        check("csr_addr", bus_a.imm_out[11:0], 12'h305);
        check("csr_wb", bus_a.wb_mux_sel_out, 4);

        step(32'h0, 0, 0, 1, 0);
        for (int n = 0; n < 20; n++) step(rand_instr(), 1, 0, 1, 1);
        check("sat_count_b", bus_b.dec_count_out, 15);
        check("count_a_20", bus_a.dec_count_out, 20);
        step(32'hFFF00093, 1, 0, 1, 0);                    // reset mid-stream
        check("midrst_valid", bus_b.out_valid_out, 0);
        check("midrst_count", bus_b.dec_count_out, 0);

        for (int n = 0; n < 600; n++) begin
            step(rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 7, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Registered, parametrised RV32 instruction decode stage. It sits between the fetch buffer and the execute stage. Beyond the base integer decode it adds optional M-extension and Zicsr decode, illegal-instruction detection, immediate generation, and register-file address extraction. One output register carries all decoded fields, with a valid/ready handshake, pipeline flush, and a saturating decoded-instruction counter.

Parameters:
EN_M_EXT, 1, 1 = decode OP with funct7=0000001 as MUL/DIV; 0 = such encodings are flagged illegal
EN_CSR, 1, 1 = decode SYSTEM funct3!=000 as CSR ops; 0 = flagged illegal
PC_WIDTH, 32, width of the program counter carried alongside the instruction
CNT_WIDTH, 16, width of the decoded-instruction counter

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_n_in  input  1  synchronous active-low reset
instr_in  input  32  fetched instruction
pc_in  input  PC_WIDTH  PC of instr_in
in_valid_in  input  1  instr_in/pc_in valid
in_ready_out  output  1  stage can accept this cycle
flush_in  input  1  discard held and incoming instruction
out_ready_in  input  1  execute stage accepts
out_valid_out  output  1  decoded bundle valid
pc_out  output  PC_WIDTH  registered PC
rd_addr_out / rs1_addr_out / rs2_addr_out  output  5 each  instr[11:7] / [19:15] / [24:20]
imm_out  output  32  generated, sign-extended immediate
imm_type_out  output  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR-zimm
alu_opcode_out  output  5  [2:0]=funct3, [3]=funct7[5] gated, [4]=M-ext op
alu_src_out  output  1  1 = rs2, 0 = immediate
iadder_src_out  output  1  1 = rs1 base (load/store/jalr), 0 = pc base
wb_mux_sel_out  output  3  0 ALU, 1 load, 2 imm (LUI), 3 iadder (AUIPC), 4 CSR, 5 pc+4 (JAL/JALR)
wr_en_out  output  1  rd write enable; forced 0 when rd==0 or illegal
mem_wr_req_out  output  1  store
mem_rd_req_out  output  1  load
load_size_out  output  2  funct3[1:0]
load_unsigned_out  output  1  funct3[2]
branch_out / jump_out  output  1 each  conditional branch / JAL or JALR
csr_op_out  output  1  Zicsr op; csr_addr = imm_out[11:0]
ecall_out / ebreak_out  output  1 each  SYSTEM traps
fence_out  output  1  MISC-MEM
illegal_out  output  1  unsupported or malformed encoding
dec_count_out  output  CNT_WIDTH  accepted-instruction count, saturating

Behaviour:
- Reset (rst_n_in low at an edge): out_valid_out=0, dec_count_out=0, all registered fields 0. Reset overrides flush and the handshake. in_ready_out=1 from the first cycle after reset.
- in_ready_out = !out_valid_out | out_ready_in. This is combinational; there is no skid buffer.
- Accept = in_valid_in & in_ready_out & !flush_in. On accept, all fields are decoded combinationally from instr_in and registered. Latency is 1 cycle: the bundle is visible on the outputs the cycle after accept.
- On out_valid_out & out_ready_in without a new accept, out_valid_out clears next cycle. Back-to-back accepts give one bundle per cycle.
- While out_valid_out=1 and out_ready_in=0, every output holds stable.
- flush_in=1: out_valid_out clears next cycle, and any instruction presented that cycle is dropped and not counted. Field registers may keep stale data.
- alu_opcode_out[3] = funct7[5] for OP and for OP-IMM shifts (funct3 001/101). It is 0 for all other OP-IMM ops and all non-ALU opcodes.
- alu_opcode_out[4] = 1 only when EN_M_EXT=1, opcode is OP, and funct7=0000001.
- Immediate: standard RV32 I/S/B/U/J formats, sign-extended to 32 bits. CSR-zimm is zero-extended instr[19:15]; csr_addr is instr[31:20], placed in imm_out[11:0] with upper bits 0.
- illegal_out=1 when any of the following holds:
  - opcode is not in {LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI, AUIPC, MISC-MEM, SYSTEM};
  - instr[1:0]!=11;
  - load funct3 is 011, 110 or 111;
  - store funct3 > 010;
  - branch funct3 is 010 or 011;
  - OP funct7 is not in {0000000, 0100000, 0000001 when EN_M_EXT=1}, or funct7=0100000 with funct3 not in {000, 101};
  - shift-immediate funct7 is invalid;
  - SYSTEM funct3!=000 when EN_CSR=0;
  - SYSTEM funct3=000 with an instr[31:20] that is neither ECALL nor EBREAK.
- When illegal_out=1: wr_en_out, mem_wr_req_out, mem_rd_req_out, branch_out, jump_out and csr_op_out are all 0, but the bundle is still issued valid so execute can trap.
- dec_count_out increments by 1 per accept and saturates at all-ones, with no wrap.

Test Plan:
- Reset, then accept ADDI x1,x0,-1 (0xFFF00093) with out_ready_in=1 → next cycle out_valid_out=1, imm_out=0xFFFFFFFF, imm_type_out=1, alu_opcode_out=00000, wb_mux_sel_out=0, wr_en_out=1, dec_count_out=1.
- Accept SRAI x2,x2,3 (0x40315113) → alu_opcode_out=01101. Accept SUB (0x40208033) → alu_opcode_out=01000. Accept MUL (0x02208033) with EN_M_EXT=1 → 10000; the same MUL with EN_M_EXT=0 → illegal_out=1, wr_en_out=0.
- Hold out_ready_in=0 for 3 cycles after a valid JAL (0x008000EF) → in_ready_out=0, outputs stable with imm_out=8, jump_out=1, wb_mux_sel_out=5. On release → the next instruction is accepted the same cycle.
- Assert flush_in while out_valid_out=1 and a new instruction is presented → out_valid_out=0 next cycle, dec_count_out unchanged.
- Present instructions 0x00000000, 0xFFFFFFFF, and CSRRW (0x30529073) with EN_CSR=0 → illegal_out=1 in each case; with EN_CSR=1 the CSRRW gives csr_op_out=1, imm_out[11:0]=0x305, wb_mux_sel_out=4.
- Set CNT_WIDTH=4 and stream 20 accepts → dec_count_out reaches 15 and stays at 15. Pull rst_n_in low mid-stream → out_valid_out=0 and dec_count_out=0 on the next edge.
